// File: rtl/deser_shiftreg_if.sv
// Word-side val/rdy channel of the serial receiver.
// master = receiver presenting words, slave = downstream consumer.
interface deser_shiftreg_if #(
    parameter int bitwidth = 32
);
    logic                recv_val;
    logic                recv_rdy;
    logic [bitwidth-1:0] recv_msg;

    modport master (
        output recv_val,
        output recv_msg,
        input  recv_rdy
    );

    modport slave (
        input  recv_val,
        input  recv_msg,
        output recv_rdy
    );
endinterface

// File: rtl/deser_shiftreg.sv
// Serial-in, parallel-out receiver: MSB-first bits assembled into a word and offered on val/rdy.
// Optional DESER_PARITY_EN: each frame carries a trailing even-parity bit, reported on parity_err.
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | accepting data bits into sreg, cnt = bits received so far
// PARITY  | all data bits in, waiting for the parity bit (parity build only)
// HOLD    | word complete, recv_val high until the consumer takes it
module deser_shiftreg #(
    parameter int bitwidth = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic in,
    input  logic shift_en,
    output logic overrun,
`ifdef DESER_PARITY_EN
    output logic parity_err,
`endif
    deser_shiftreg_if.master recv
);
    localparam int CNT_W = $clog2(bitwidth + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(bitwidth - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        PARITY  = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [bitwidth-1:0] sreg;
    logic                val_q;

    assign recv.recv_val = val_q;
    assign recv.recv_msg = sreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= COLLECT;
            cnt     <= '0;
            sreg    <= '0;
            val_q   <= 1'b0;
            overrun <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (clr) begin
            state   <= COLLECT;
            cnt     <= '0;
            sreg    <= '0;
            val_q   <= 1'b0;
            overrun <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (shift_en) begin
                        sreg <= {sreg[bitwidth-2:0], in};
                        if (cnt == LAST) begin
                            cnt <= '0;
`ifdef DESER_PARITY_EN
                            state <= PARITY;
`else
                            state <= HOLD;
                            val_q <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`ifdef DESER_PARITY_EN
                PARITY: begin
                    // parity bit is checked against the word, never shifted in
                    if (shift_en) begin
                        parity_err <= (^sreg) ^ in;
                        state      <= HOLD;
                        val_q      <= 1'b1;
                    end
                end
`endif
                HOLD: begin
                    if (recv.recv_rdy) begin
                        val_q <= 1'b0;
                        state <= COLLECT;
                        // bit arriving with the handshake starts the next word
                        if (shift_en) begin
                            sreg <= {sreg[bitwidth-2:0], in};
                            cnt  <= CNT_W'(1);
                        end
                    end else if (shift_en) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_deser_shiftreg.sv
// Scoreboarded bench for deser_shiftreg at bitwidth 8; the monitor pops expected words on each handshake.
module tb_deser_shiftreg;
    localparam int BW = 8;
`ifdef DESER_PARITY_EN
    localparam int FRAME = BW + 1;
`else
    localparam int FRAME = BW;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clr = 1'b0;
    logic sin = 1'b0;
    logic shift_en = 1'b0;
    logic overrun;
`ifdef DESER_PARITY_EN
    logic parity_err;
`endif

    deser_shiftreg_if #(.bitwidth(BW)) bus ();

    deser_shiftreg #(.bitwidth(BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .in       (sin),
        .shift_en (shift_en),
        .overrun  (overrun),
`ifdef DESER_PARITY_EN
        .parity_err (parity_err),
`endif
        .recv     (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] msg;
        logic          perr;
    } exp_t;

    exp_t exp_q[$];
    longint hs_t[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // monitor: a handshake completes at the next posedge
    always @(negedge clk) begin
        if (!reset && bus.recv_val === 1'b1 && bus.recv_rdy === 1'b1) begin
            hs_t.push_back(longint'($time));
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(bus.recv_msg), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word", 32'(bus.recv_msg), 32'(e.msg));
`ifdef DESER_PARITY_EN
                chk("parity_err", 32'(parity_err), 32'(e.perr));
`endif
            end
        end
    end

    task automatic send_bit(input logic b);
        sin      = b;
        shift_en = 1'b1;
        @(posedge clk);
        #1;
        shift_en = 1'b0;
    endtask

    task automatic send_word(input logic [BW-1:0] w, input logic par, input int gap,
                             input bit push, input bit early_chk);
        exp_t e;
        if (push) begin
            e.msg  = w;
            e.perr = par ^ (^w);
            exp_q.push_back(e);
        end
        for (int i = FRAME - 1; i >= 0; i--) begin
            if (i == FRAME - 5 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
                if (early_chk) chk("gap_no_val", 32'(bus.recv_val), 32'd0);
            end
            if (early_chk && i == 0) chk("no_early_val", 32'(bus.recv_val), 32'd0);
            if (i >= FRAME - BW) send_bit(w[i-(FRAME-BW)]);
            else send_bit(par);
        end
    endtask

    task automatic consume();
        bus.recv_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.recv_rdy = 1'b0;
        chk("val_after_consume", 32'(bus.recv_val), 32'd0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.recv_rdy = 1'b0;
        #12;
        chk("reset_val", 32'(bus.recv_val), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
`ifdef DESER_PARITY_EN
        chk("reset_parity_err", 32'(parity_err), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // basic receive, held until consumed
        send_word(8'hA5, 1'b0, 0, 1'b1, 1'b1);
        chk("basic_val", 32'(bus.recv_val), 32'd1);
        chk("basic_msg", 32'(bus.recv_msg), 32'hA5);
        repeat (3) @(posedge clk);
        #1;
        chk("basic_hold_val", 32'(bus.recv_val), 32'd1);
        chk("basic_hold_msg", 32'(bus.recv_msg), 32'hA5);
        consume();

        // gapped input
        send_word(8'hA5, 1'b0, 3, 1'b1, 1'b1);
        chk("gap_val", 32'(bus.recv_val), 32'd1);
        chk("gap_msg", 32'(bus.recv_msg), 32'hA5);
        consume();

        // full-rate streaming
        hs_t.delete();
        bus.recv_rdy = 1'b1;
        send_word(8'h3C, 1'b0, 0, 1'b1, 1'b0);
        send_word(8'hC3, 1'b0, 0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.recv_rdy = 1'b0;
        chk("stream_handshakes", 32'(hs_t.size()), 32'd2);
        if (hs_t.size() == 2)
            chk("stream_spacing", 32'(hs_t[1] - hs_t[0]), 32'(FRAME * 10));
        chk("stream_overrun", 32'(overrun), 32'd0);

        // overrun
        send_word(8'hFF, 1'b0, 0, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("ovr_msg", 32'(bus.recv_msg), 32'hFF);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_val", 32'(bus.recv_val), 32'd1);
        consume();
        chk("ovr_sticky", 32'(overrun), 32'd1);
        pulse_clr();
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // abort partial word, then a clean word
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        pulse_clr();
        send_word(8'h81, 1'b0, 0, 1'b1, 1'b1);
        chk("abort_msg", 32'(bus.recv_msg), 32'h81);
        consume();

        // clr discards a held word, with a simultaneous bit ignored
        send_word(8'h5A, 1'b0, 0, 1'b0, 1'b0);
        sin = 1'b1;
        shift_en = 1'b1;
        pulse_clr();
        shift_en = 1'b0;
        chk("clr_held_val", 32'(bus.recv_val), 32'd0);
        chk("clr_held_msg", 32'(bus.recv_msg), 32'd0);

        // async reset mid-word, then async reset on a held word
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #2 reset = 1'b1;
        #1 chk("rst_mid_val", 32'(bus.recv_val), 32'd0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        send_word(8'h81, 1'b0, 0, 1'b0, 1'b1);
        chk("rst_held_pre", 32'(bus.recv_val), 32'd1);
        #2 reset = 1'b1;
        #1 chk("rst_async_val", 32'(bus.recv_val), 32'd0);
        chk("rst_async_msg", 32'(bus.recv_msg), 32'd0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        send_word(8'h24, 1'b0, 0, 1'b1, 1'b1);
        chk("post_rst_msg", 32'(bus.recv_msg), 32'h24);
        consume();

`ifdef DESER_PARITY_EN
        send_word(8'hA5, 1'b0, 0, 1'b1, 1'b1);
        chk("par_ok_val", 32'(bus.recv_val), 32'd1);
        chk("par_ok_err", 32'(parity_err), 32'd0);
        consume();
        send_word(8'hA5, 1'b1, 0, 1'b1, 1'b1);
        chk("par_bad_val", 32'(bus.recv_val), 32'd1);
        chk("par_bad_err", 32'(parity_err), 32'd1);
        chk("par_bad_msg", 32'(bus.recv_msg), 32'hA5);
        consume();
`endif

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
